pattern_detect_fsm: RTL and testbench
=====================================

# pattern_detect_fsm

Parametrised, run-time programmable serial sequence detector. Samples a 1-bit stream `w` under a valid strobe and compares it against a pattern of 1..MAX_LEN bits. It pulses `z` on each match, in overlapping or non-overlapping mode, and keeps a saturating match count. It replaces the fixed-pattern hard-coded detector FSMs in the control path, so new patterns need a register write instead of a new block.

## Interface
Parameters:
- MAX_LEN, 8: longest supported pattern in bits (2..32).
- COUNT_W, 8: width of `match_count`.
- RST_PATTERN, 8'b0000_0011: pattern register value after reset, right-aligned, newest bit at LSB.
- RST_LEN, 2: pattern length after reset (1..MAX_LEN).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately; release is synchronous to `clk`.
- enable  in  1  1 = detector running; 0 = idle, history flushed.
- w  in  1  serial data bit.
- w_valid  in  1  `w` is sampled on edges where `w_valid` = 1 and the detector is running.
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- cfg_load  in  1  one-cycle strobe; writes `cfg_pattern`/`cfg_len`.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit 0 = most recent bit of the sequence.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- count_clr  in  1  synchronous clear of `match_count`.
- z  out  1  one-cycle match pulse, registered.
- match_count  out  COUNT_W  saturating number of matches since reset/clear.
- cfg_err  out  1  one-cycle pulse on a rejected `cfg_load`.
- state_o  out  2  current FSM state (IDLE=0, FILL=1, RUN=2), for debug.

## Operation
- Internal registers: `pat[MAX_LEN-1:0]`, `len`, history shift register `hist[MAX_LEN-1:0]`, fill counter `fill` (0..MAX_LEN).
- Accepted sample: `hist <= {hist[MAX_LEN-2:0], w}`. `fill` increments and saturates at `len`.
- Match condition: `fill` (after update) == `len` and `hist[len-1:0] == pat[len-1:0]` (after update). Bits above `len` are ignored.
- FSM states:
  - IDLE: entered when `enable` = 0. Goes to FILL when `enable` = 1.
  - FILL: `fill` < `len`; samples are accepted but no match is possible. Goes to RUN when `fill` reaches `len`.
  - RUN: a match is evaluated on every accepted sample.
    - On a match with `overlap` = 1: stay in RUN, history kept.
    - On a match with `overlap` = 0: `fill` <= 0 and go to FILL. `hist` is not cleared.
  - Any state: `enable` = 0 forces IDLE next edge; `hist` <= 0 and `fill` <= 0.
- Configuration:
  - `cfg_load` is accepted only in IDLE with 1 <= `cfg_len` <= MAX_LEN.
  - Otherwise `pat`/`len` are unchanged and `cfg_err` = 1 for one cycle.
- `len` = 1 is legal: every accepted sample equal to `pat[0]` is a match.
- `match_count`:
  - Increments by 1 per match and saturates at 2^COUNT_W−1.
  - `count_clr` with a match on the same edge gives `match_count` = 1. `count_clr` alone gives 0.
  - `match_count` is kept across `enable` toggles.
- `w_valid` = 0 in FILL/RUN: nothing changes, and `z` = 0 on the next cycle.

## Timing
- Reset values: `z` = 0, `match_count` = 0, `cfg_err` = 0, `state_o` = IDLE, `hist` = 0, `fill` = 0, `pat` = RST_PATTERN, `len` = RST_LEN.
- Latency: a sample accepted at edge N that completes a match gives `z` = 1 during cycle N..N+1. `match_count` shows the new value in the same cycle.
- Back-to-back accepted samples give at most one `z` pulse per sample. In overlap mode `z` may be high on consecutive cycles.
- `enable` 1->0 at edge N: state is IDLE after N. A match completing at edge N is suppressed (`z` = 0, no count).
- `enable` 0->1 at edge N: state is FILL after N. The first sample is accepted at edge N+1 at the earliest.
- `cfg_load` at edge N with `enable` = 0: new `pat`/`len` are used for all samples from the next enable. `cfg_err` is valid in cycle N..N+1.
- `overlap` is sampled on the edge of the match. Changing it mid-stream only affects later matches.
- `reset` asserted mid-stream: all outputs reach their reset values immediately, with no clock required.

## Test plan
- Reset then enable=1, overlap=1, load pattern 4'b1011/len 4 beforehand, feed w = 1,0,1,1,0,1,1 (valid every cycle) -> `z` pulses after samples 4 and 7; `match_count` = 2.
- Same stream, overlap=0 -> single `z` after sample 4; `match_count` = 1.
- `w_valid` gaps: pattern 2'b11, feed 1, gap ×3, 1 -> `z` one cycle after the second valid sample; no pulse during gaps.
- `cfg_load` with `cfg_len` = 0, and `cfg_load` while enabled -> `cfg_err` pulse each time; `pat`/`len` unchanged (RST values still detected).
- COUNT_W=2, pattern len 1 = 1'b1, feed six 1s -> `match_count` saturates at 3. `count_clr` coincident with a match -> `match_count` = 1.
- Assert `reset` asynchronously mid-FILL and drop `enable` on a matching edge -> outputs zero immediately / no `z`, `state_o` = IDLE.

Source files
------------

// File: rtl/pattern_detect_fsm.sv
// Run-time programmable serial sequence detector: compares the sampled stream `w`
// against a 1..MAX_LEN bit pattern and pulses `z` on every match.
module pattern_detect_fsm #(
    parameter int                  MAX_LEN     = 8,
    parameter int                  COUNT_W     = 8,
    parameter logic [MAX_LEN-1:0]  RST_PATTERN = 8'b0000_0011,
    parameter int                  RST_LEN     = 2,
    localparam int                 LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               w,
    input  logic               w_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               count_clr,
    output logic               z,
    output logic [COUNT_W-1:0] match_count,
    output logic               cfg_err,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pat, hist, hist_next, hist_shift, mask;
    logic [LW-1:0]      len, fill, fill_next, fill_inc;
    logic               match;
    logic               cfg_ok;

    assign hist_shift = {hist[MAX_LEN-2:0], w};
    assign fill_inc   = (fill >= len) ? len : fill + LW'(1);
    assign cfg_ok     = (state == IDLE) && (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

    // Only the low `len` history bits take part in the comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    // State register and detector datapath.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hist  <= '0;
            fill  <= '0;
            pat   <= RST_PATTERN;
            len   <= LW'(RST_LEN);
        end else begin
            state <= state_next;
            hist  <= hist_next;
            fill  <= fill_next;
            if (cfg_load && cfg_ok) begin
                pat <= cfg_pattern;
                len <= cfg_len;
            end
        end
    end

    // Next-state logic; a match is evaluated on any accepted sample that fills the window.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        hist_next  = hist;
        fill_next  = fill;
        match      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            hist_next  = '0;
            fill_next  = '0;
        end else begin
            case (state)
                IDLE: state_next = FILL;
                FILL, RUN: begin
                    if (w_valid) begin
                        hist_next = hist_shift;
                        fill_next = fill_inc;
                        if (fill_inc == len) begin
                            match = ((hist_shift ^ pat) & mask) == '0;
                            if (match && !overlap) begin
                                fill_next  = '0;
                                state_next = FILL;
                            end else begin
                                state_next = RUN;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z           <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            z       <= match;
            cfg_err <= cfg_load && !cfg_ok;
            if (count_clr)
                match_count <= match ? COUNT_W'(1) : '0;
            else if (match && match_count != '1)
                match_count <= match_count + COUNT_W'(1);
        end
    end

    always_comb begin
        state_o = state;
    end

endmodule

// File: tb/tb_pattern_detect_fsm.sv
// Self-checking bench for pattern_detect_fsm: table-driven vectors plus
// hand-written sequences for asynchronous reset and reset-pattern recovery.
module tb_pattern_detect_fsm;

    localparam int MAX_LEN = 8;
    localparam int COUNT_W = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               enable, w, w_valid, overlap, cfg_load, count_clr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               z, cfg_err;
    logic [COUNT_W-1:0] match_count;
    logic [1:0]         state_o;

    int checks = 0;
    int errors = 0;

    pattern_detect_fsm #(.MAX_LEN(MAX_LEN), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .w(w), .w_valid(w_valid),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .count_clr(count_clr), .z(z), .match_count(match_count),
        .cfg_err(cfg_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, wv, wb, ov, ld, clr;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ez;
        int         ecnt;
        logic       eerr;
        int         est;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic wv, logic wb, logic ov, logic ld,
                                logic [7:0] pat, logic [3:0] len, logic clr,
                                logic ez, int ecnt, logic eerr, int est);
        vec_t v;
        v.en = en; v.wv = wv; v.wb = wb; v.ov = ov; v.ld = ld; v.pat = pat;
        v.len = len; v.clr = clr; v.ez = ez; v.ecnt = ecnt; v.eerr = eerr; v.est = est;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic en, input logic wv, input logic wb, input logic ov,
                         input logic ld, input logic [7:0] pat, input logic [3:0] len,
                         input logic clr);
        enable = en; w_valid = wv; w = wb; overlap = ov;
        cfg_load = ld; cfg_pattern = pat; cfg_len = len; count_clr = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ez, input int ecnt,
                              input logic eerr, input int est);
        check({tag, " z"}, int'(z), int'(ez));
        check({tag, " count"}, int'(match_count), ecnt);
        check({tag, " cfg_err"}, int'(cfg_err), int'(eerr));
        check({tag, " state"}, int'(state_o), est);
    endtask

    initial begin
        //               en wv w  ov ld pat          len clr   z cnt err st
        // Overlap: pattern 1011, stream 1,0,1,1,0,1,1 -> matches at 4 and 7.
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'b1011,     4, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 1, 0, 2));
        tbl.push_back(mk(1, 1, 0, 1, 0, 8'h00,       0, 0,   0, 1, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   0, 1, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 2, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00,       0, 0,   0, 2, 0, 0));
        // Non-overlap: same stream gives a single match.
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00,       0, 1,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00,       0, 0,   1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00,       0, 0,   0, 1, 0, 0));
        // Valid gaps: pattern 11, sample 1, three gaps with w=1, sample 1.
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'b11,       2, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 0, 8'h00,       0, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 2, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00,       0, 0,   0, 2, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00,       0, 0,   0, 2, 0, 0));
        // Rejected loads: len 0 in IDLE, and a load while enabled; 11 still detected.
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'hFF,       0, 0,   0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00,       0, 0,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00,       0, 0,   0, 2, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'b101,      3, 0,   0, 2, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   0, 2, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 3, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00,       0, 0,   0, 3, 0, 0));
        // Saturation at 3 with len-1 pattern, then clear coincident with a match.
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'b1,        1, 1,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00,       0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 1, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 2, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 3, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 3, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 0,   1, 3, 0, 2));
        tbl.push_back(mk(1, 1, 1, 1, 0, 8'h00,       0, 1,   1, 1, 0, 2));
        tbl.push_back(mk(1, 1, 0, 1, 0, 8'h00,       0, 0,   0, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00,       0, 1,   0, 0, 0, 2));
        // Enable dropped on an edge whose sample would match: suppressed.
        tbl.push_back(mk(0, 1, 1, 1, 0, 8'h00,       0, 0,   0, 0, 0, 0));
        // Length above MAX_LEN is rejected.
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'hFF,       9, 0,   0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00,       0, 0,   0, 0, 0, 0));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
        #12;
        check_outs("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].wv, tbl[i].wb, tbl[i].ov, tbl[i].ld,
                  tbl[i].pat, tbl[i].len, tbl[i].clr);
            tick();
            check_outs($sformatf("v%0d", i), tbl[i].ez, tbl[i].ecnt, tbl[i].eerr, tbl[i].est);
        end

        // Asynchronous reset while z is high and the FSM is back in FILL.
        drive(0, 0, 0, 0, 1, 8'b1, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 8'h00, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0, 8'h00, 0, 0);
        tick();
        check_outs("pre_reset", 1, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 8'h00, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // After reset the pattern is 11 / len 2 again; a single 1 must not match.
        drive(1, 0, 0, 1, 0, 8'h00, 0, 0);
        tick();
        check_outs("post_en", 0, 0, 0, 1);
        drive(1, 1, 1, 1, 0, 8'h00, 0, 0);
        tick();
        check_outs("post_s1", 0, 0, 0, 1);
        drive(1, 1, 1, 1, 0, 8'h00, 0, 0);
        tick();
        check_outs("post_s2", 1, 1, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
